wb_write_scheduler: RTL and testbench

- Sequences Y86-64 write-back traffic onto the single write port of the general register file (registers 0..14, 4'hF = RNONE).
- A stage may request two writes per instruction: dstE/valE and dstM/valM (popq writes both). The block queues them in a small FIFO and retires one write per cycle, E before M.
- A per-register pending scoreboard gives decode a busy mask so it can stall on outstanding writes.
- Sits between the execute/memory stages and the register file.

---
 rtl/y86_pkg.sv | 28 ++
 rtl/wb_fifo.sv | 50 +++++
 rtl/wb_write_scheduler.sv | 99 +++++++++
 tb/tb_wb_write_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: register indices, RNONE and instruction codes.
package y86_pkg;

    localparam int unsigned NUM_REGS = 15;
    localparam int unsigned REG_W    = 4;

    localparam logic [3:0] RRAX  = 4'h0;
    localparam logic [3:0] RRCX  = 4'h1;
    localparam logic [3:0] RRDX  = 4'h2;
    localparam logic [3:0] RRBX  = 4'h3;
    localparam logic [3:0] RSP   = 4'h4;
    localparam logic [3:0] RRBP  = 4'h5;
    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer accepting up to two entries per cycle and releasing one.
module wb_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 68
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push0,
    input  logic [WIDTH-1:0]             data0,
    input  logic                         push1,
    input  logic [WIDTH-1:0]             data1,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] n_wr;

    assign n_wr = CNT_W'(push0) + CNT_W'(push1);
    assign head = mem[rptr];

    // push1 is only used together with push0, so it lands in the slot after data0
    always_ff @(posedge clk) begin
        if (push0) mem[wptr] <= data0;
        if (push1) mem[wptr + PTR_W'(1)] <= data1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            assert (int'(count) + int'(n_wr) - int'(pop) <= int'(DEPTH))
                else $error("wb_fifo overflow");
            assert (!(pop && count == '0))
                else $error("wb_fifo pop while empty");
            wptr  <= wptr + PTR_W'(n_wr);
            rptr  <= rptr + PTR_W'(pop);
            count <= count + n_wr - CNT_W'(pop);
        end
    end

endmodule

// File: rtl/wb_write_scheduler.sv
// Queues E/M write-backs, retires one register write per cycle, tracks pending writes.
module wb_write_scheduler
    import y86_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [3:0]        dstE,
    input  logic [DATA_W-1:0] valE,
    input  logic [3:0]        dstM,
    input  logic [DATA_W-1:0] valM,
    output logic              rf_we,
    output logic [3:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [14:0]       busy,
    output logic              idle
);

    localparam int unsigned CNT_W  = $clog2(DEPTH+1);
    localparam int unsigned PEND_W = $clog2(DEPTH+2);
    localparam int unsigned ENT_W  = REG_W + DATA_W;

    logic              e_valid;
    logic              m_valid;
    logic              accept;
    logic              push0;
    logic              push1;
    logic              pop;
    logic [ENT_W-1:0]  data0;
    logic [ENT_W-1:0]  data1;
    logic [ENT_W-1:0]  head;
    logic [CNT_W-1:0]  count;
    logic [3:0]        addr0;
    logic [3:0]        addr1;
    logic [PEND_W-1:0] pend      [NUM_REGS];
    logic [PEND_W-1:0] pend_next [NUM_REGS];

    assign e_valid  = (dstE != RNONE);
    assign m_valid  = (dstM != RNONE);
    assign wb_ready = (int'(DEPTH) - int'(count)) >= 2;
    assign accept   = wb_valid && wb_ready;

    // Compact the request so the first slot holds E if present, else M
    assign push0 = accept && (e_valid || m_valid);
    assign push1 = accept && e_valid && m_valid;
    assign data0 = e_valid ? {dstE, valE} : {dstM, valM};
    assign data1 = {dstM, valM};
    assign addr0 = data0[ENT_W-1 -: REG_W];
    assign addr1 = data1[ENT_W-1 -: REG_W];
    assign pop   = (count != '0);
    assign idle  = (count == '0) && !rf_we;

    wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push0 (push0),
        .data0 (data0),
        .push1 (push1),
        .data1 (data1),
        .pop   (pop),
        .head  (head),
        .count (count)
    );

    // Pending counters: +1 per enqueued entry, -1 at the commit edge, netted
    always_comb begin
        for (int r = 0; r < int'(NUM_REGS); r++) begin
            pend_next[r] = pend[r];
            if (push0 && addr0 == 4'(r)) pend_next[r] = pend_next[r] + PEND_W'(1);
            if (push1 && addr1 == 4'(r)) pend_next[r] = pend_next[r] + PEND_W'(1);
            if (rf_we && rf_waddr == 4'(r)) pend_next[r] = pend_next[r] - PEND_W'(1);
            busy[r] = (pend[r] != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= RNONE;
            rf_wdata <= '0;
            for (int r = 0; r < int'(NUM_REGS); r++) pend[r] <= '0;
        end else begin
            rf_we <= pop;
            if (pop) begin
                rf_waddr <= head[ENT_W-1 -: REG_W];
                rf_wdata <= head[DATA_W-1:0];
            end
            for (int r = 0; r < int'(NUM_REGS); r++) pend[r] <= pend_next[r];
        end
    end

endmodule

// File: tb/tb_wb_write_scheduler.sv
// Scoreboard bench for wb_write_scheduler: expected writes queued at accept, checked at commit.
module tb_wb_write_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic        wb_ready;
    logic [3:0]  dstE;
    logic [63:0] valE;
    logic [3:0]  dstM;
    logic [63:0] valM;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic [14:0] busy;
    logic        idle;

    logic [67:0] exp_q [$];
    int checks  = 0;
    int errors  = 0;
    int commits = 0;
    int cyc     = 0;
    int last_cyc = 0;

    wb_write_scheduler #(.DEPTH(4), .DATA_W(64)) dut (
        .clk      (clk),
        .rst      (rst),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .dstE     (dstE),
        .valE     (valE),
        .dstM     (dstM),
        .valM     (valM),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .busy     (busy),
        .idle     (idle)
    );

    always #5 clk = ~clk;

    task automatic cycle_counter();
        forever begin
            @(posedge clk);
            cyc++;
        end
    endtask

    // Every committed write must match the oldest expected write
    task automatic monitor();
        logic [67:0] exp;
        forever begin
            @(negedge clk);
            if (!rst && rf_we) begin
                commits++;
                last_cyc = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write got addr=%h data=%h, none expected", rf_waddr, rf_wdata);
                end else begin
                    exp = exp_q.pop_front();
                    if ({rf_waddr, rf_wdata} !== exp) begin
                        errors++;
                        $display("FAIL commit got addr=%h data=%h expected addr=%h data=%h",
                                 rf_waddr, rf_wdata, exp[67:64], exp[63:0]);
                    end
                end
            end
        end
    endtask

    // Returns #1 after the accepting edge
    task automatic send(input logic [3:0] e, input logic [63:0] ve,
                        input logic [3:0] m, input logic [63:0] vm);
        int n = 0;
        @(negedge clk);
        wb_valid = 1'b1;
        dstE = e; valE = ve; dstM = m; valM = vm;
        while (!wb_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!wb_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout wb_ready=%b expected 1 within 50 cycles", wb_ready);
            wb_valid = 1'b0;
            return;
        end
        if (e != 4'hF) exp_q.push_back({e, ve});
        if (m != 4'hF) exp_q.push_back({m, vm});
        @(posedge clk);
        #1;
        wb_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(idle && exp_q.size() == 0) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (!(idle && exp_q.size() == 0)) begin
            errors++;
            $display("FAIL drain idle=%b pending=%0d expected idle=1 pending=0", idle, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wb_valid = 1'b0;
        dstE = 4'hF; dstM = 4'hF; valE = '0; valM = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 4'hF, 64'h0}) begin
            errors++;
            $display("FAIL reset_port got we=%b addr=%h data=%h expected 0/f/0", rf_we, rf_waddr, rf_wdata);
        end
        checks++;
        if ({busy, idle, wb_ready} !== {15'h0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL reset_status got busy=%h idle=%b ready=%b expected 0/1/1", busy, idle, wb_ready);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        send(4'd3, 64'h10, 4'hF, 64'h0);
        checks++;
        if (rf_we !== 1'b0 || busy !== 15'h0008) begin
            errors++;
            $display("FAIL single_accept got we=%b busy=%h expected 0/0008", rf_we, busy);
        end
        @(posedge clk); #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 4'd3, 64'h10} || busy !== 15'h0008) begin
            errors++;
            $display("FAIL single_write got we=%b addr=%h data=%h busy=%h expected 1/3/10/0008",
                     rf_we, rf_waddr, rf_wdata, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (rf_we !== 1'b0 || busy !== 15'h0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL single_after got we=%b busy=%h idle=%b expected 0/0/1", rf_we, busy, idle);
        end
        wait_idle();
    endtask

    task automatic test_popq();
        send(4'd4, 64'h100, 4'd4, 64'hAB);
        @(posedge clk); #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 4'd4, 64'h100} || busy !== 15'h0010) begin
            errors++;
            $display("FAIL popq_e got we=%b addr=%h data=%h busy=%h expected 1/4/100/0010",
                     rf_we, rf_waddr, rf_wdata, busy);
        end
        @(posedge clk); #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 4'd4, 64'hAB} || busy !== 15'h0010) begin
            errors++;
            $display("FAIL popq_m got we=%b addr=%h data=%h busy=%h expected 1/4/ab/0010",
                     rf_we, rf_waddr, rf_wdata, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (rf_we !== 1'b0 || busy !== 15'h0) begin
            errors++;
            $display("FAIL popq_clear got we=%b busy=%h expected 0/0", rf_we, busy);
        end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        int a_cyc;
        int c0;
        c0 = commits;
        send(4'd1, 64'hA1, 4'd2, 64'hA2);
        a_cyc = cyc;
        send(4'd3, 64'hB3, 4'd5, 64'hB5);
        checks++;
        if (wb_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ready got %b expected 0", wb_ready);
        end
        send(4'd6, 64'hC6, 4'd7, 64'hC7);
        send(4'd8, 64'hD8, 4'd9, 64'hD9);
        wait_idle();
        checks++;
        if (commits - c0 != 8 || last_cyc != a_cyc + 8) begin
            errors++;
            $display("FAIL b2b_stream got commits=%0d span_end=%0d expected 8/%0d",
                     commits - c0, last_cyc - a_cyc, 8);
        end
    endtask

    task automatic test_none();
        int c0;
        c0 = commits;
        send(4'hF, 64'h1, 4'hF, 64'h2);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rf_we !== 1'b0 || busy !== 15'h0 || idle !== 1'b1) begin
                errors++;
                $display("FAIL none_cycle%0d got we=%b busy=%h idle=%b expected 0/0/1", i, rf_we, busy, idle);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (commits != c0) begin
            errors++;
            $display("FAIL none_commits got %0d expected %0d", commits, c0);
        end
    endtask

    task automatic test_async_reset();
        int c0;
        send(4'd10, 64'h1A, 4'd11, 64'h1B);
        send(4'd12, 64'h1C, 4'd13, 64'h1D);
        c0 = commits;
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        checks++;
        if (rf_we !== 1'b0 || busy !== 15'h0 || wb_ready !== 1'b1 || idle !== 1'b1) begin
            errors++;
            $display("FAIL async_reset got we=%b busy=%h ready=%b idle=%b expected 0/0/1/1",
                     rf_we, busy, wb_ready, idle);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (commits != c0 || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_quiet got commits=%0d we=%b expected %0d/0", commits, rf_we, c0);
        end
        send(4'd1, 64'h5, 4'hF, 64'h0);
        wait_idle();
        checks++;
        if (commits != c0 + 1) begin
            errors++;
            $display("FAIL post_reset_write got commits=%0d expected %0d", commits, c0 + 1);
        end
    endtask

    task automatic test_netting();
        send(4'd2, 64'h22, 4'hF, 64'h0);
        @(posedge clk); #1;
        checks++;
        if ({rf_we, rf_waddr} !== {1'b1, 4'd2} || busy[2] !== 1'b1) begin
            errors++;
            $display("FAIL net_first got we=%b addr=%h busy2=%b expected 1/2/1", rf_we, rf_waddr, busy[2]);
        end
        send(4'd2, 64'h33, 4'hF, 64'h0);
        checks++;
        if (busy !== 15'h0004 || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL net_same_edge got busy=%h we=%b expected 0004/0", busy, rf_we);
        end
        @(posedge clk); #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 4'd2, 64'h33} || busy !== 15'h0004) begin
            errors++;
            $display("FAIL net_second got we=%b addr=%h data=%h busy=%h expected 1/2/33/0004",
                     rf_we, rf_waddr, rf_wdata, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 15'h0) begin
            errors++;
            $display("FAIL net_clear got busy=%h expected 0", busy);
        end
        wait_idle();
    endtask

    initial begin
        fork
            cycle_counter();
            monitor();
        join_none
        test_reset();
        test_single();
        test_popq();
        test_back_to_back();
        test_none();
        test_async_reset();
        test_netting();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
